decoder_core: RTL and testbench

Combinational RV32I main decoder in the processor core's decode stage. It takes the fetched 32-bit instruction and produces operand-select, ALU-operation, memory-control, write-back and control-flow signals for the datapath, and it flags illegal instructions. A single registered sticky flag records that an illegal instruction was seen.

---
 rtl/decoder_core.sv | 194 +++++++++++++++++++
 tb/tb_decoder_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_core.sv
// RV32I main decoder: purely combinational decode of the fetched instruction word,
// plus a sticky flag that remembers any illegal instruction seen since reset.
module decoder_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetched_instr_i,
    output logic [1:0]  ex_op_a_sel_o,
    output logic [2:0]  ex_op_b_sel_o,
    output logic [4:0]  alu_op_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic        gpr_we_a_o,
    output logic        wb_src_sel_o,
    output logic        illegal_instr_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_seen_o
);
    localparam logic [4:0] OpcLoad    = 5'b00000;
    localparam logic [4:0] OpcMiscMem = 5'b00011;
    localparam logic [4:0] OpcOpImm   = 5'b00100;
    localparam logic [4:0] OpcAuipc   = 5'b00101;
    localparam logic [4:0] OpcStore   = 5'b01000;
    localparam logic [4:0] OpcOp      = 5'b01100;
    localparam logic [4:0] OpcLui     = 5'b01101;
    localparam logic [4:0] OpcBranch  = 5'b11000;
    localparam logic [4:0] OpcJalr    = 5'b11001;
    localparam logic [4:0] OpcJal     = 5'b11011;
    localparam logic [4:0] OpcSystem  = 5'b11100;

    localparam logic [1:0] OpARs1 = 2'd0, OpAPc = 2'd1, OpAZero = 2'd2;
    localparam logic [2:0] OpBRs2 = 3'd0, OpBImmI = 3'd1, OpBImmU = 3'd2;
    localparam logic [2:0] OpBImmS = 3'd3, OpBIncr = 3'd4;

    localparam logic [4:0] AluAdd = 5'b00000, AluSub = 5'b01000, AluSll = 5'b00001;
    localparam logic [4:0] AluSlts = 5'b00010, AluSltu = 5'b00011, AluXor = 5'b00100;
    localparam logic [4:0] AluSrl = 5'b00101, AluSra = 5'b01101, AluOr = 5'b00110;
    localparam logic [4:0] AluAnd = 5'b00111, AluEq = 5'b11000, AluNe = 5'b11001;
    localparam logic [4:0] AluLts = 5'b11100, AluGes = 5'b11101, AluLtu = 5'b11110;
    localparam logic [4:0] AluGeu = 5'b11111;

    localparam logic [2:0] SizeW = 3'd2;

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal;
    logic       illegal_seen_q, illegal_seen_d;
    logic       unused_bits;

    assign opc = fetched_instr_i[6:2];
    assign f3  = fetched_instr_i[14:12];
    assign f7  = fetched_instr_i[31:25];
    assign unused_bits = ^{fetched_instr_i[24:15], fetched_instr_i[11:7]};

    always_comb begin
        ex_op_a_sel_o = OpARs1;
        ex_op_b_sel_o = OpBRs2;
        alu_op_o      = AluAdd;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_size_o    = SizeW;
        gpr_we_a_o    = 1'b0;
        wb_src_sel_o  = 1'b0;
        branch_o      = 1'b0;
        jal_o         = 1'b0;
        jalr_o        = 1'b0;
        illegal       = (fetched_instr_i[1:0] != 2'b11);

        case (opc)
            OpcLoad: begin
                ex_op_b_sel_o = OpBImmI;
                mem_req_o     = 1'b1;
                gpr_we_a_o    = 1'b1;
                wb_src_sel_o  = 1'b1;
                mem_size_o    = f3;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal = 1'b1;
            end
            OpcStore: begin
                ex_op_b_sel_o = OpBImmS;
                mem_req_o     = 1'b1;
                mem_we_o      = 1'b1;
                mem_size_o    = f3;
                if (f3 > 3'd2) illegal = 1'b1;
            end
            OpcOpImm: begin
                ex_op_b_sel_o = OpBImmI;
                gpr_we_a_o    = 1'b1;
                case (f3)
                    3'd0: alu_op_o = AluAdd;
                    3'd1: begin
                        alu_op_o = AluSll;
                        if (f7 != 7'h00) illegal = 1'b1;
                    end
                    3'd2: alu_op_o = AluSlts;
                    3'd3: alu_op_o = AluSltu;
                    3'd4: alu_op_o = AluXor;
                    3'd5: begin
                        if (f7 == 7'h00)      alu_op_o = AluSrl;
                        else if (f7 == 7'h20) alu_op_o = AluSra;
                        else                  illegal  = 1'b1;
                    end
                    3'd6: alu_op_o = AluOr;
                    default: alu_op_o = AluAnd;
                endcase
            end
            OpcOp: begin
                gpr_we_a_o = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: alu_op_o = AluAdd;
                        3'd1: alu_op_o = AluSll;
                        3'd2: alu_op_o = AluSlts;
                        3'd3: alu_op_o = AluSltu;
                        3'd4: alu_op_o = AluXor;
                        3'd5: alu_op_o = AluSrl;
                        3'd6: alu_op_o = AluOr;
                        default: alu_op_o = AluAnd;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    alu_op_o = AluSub;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    alu_op_o = AluSra;
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcLui: begin
                ex_op_a_sel_o = OpAZero;
                ex_op_b_sel_o = OpBImmU;
                gpr_we_a_o    = 1'b1;
            end
            OpcAuipc: begin
                ex_op_a_sel_o = OpAPc;
                ex_op_b_sel_o = OpBImmU;
                gpr_we_a_o    = 1'b1;
            end
            OpcBranch: begin
                branch_o = 1'b1;
                case (f3)
                    3'd0: alu_op_o = AluEq;
                    3'd1: alu_op_o = AluNe;
                    3'd4: alu_op_o = AluLts;
                    3'd5: alu_op_o = AluGes;
                    3'd6: alu_op_o = AluLtu;
                    3'd7: alu_op_o = AluGeu;
                    default: illegal = 1'b1;
                endcase
            end
            OpcJal: begin
                ex_op_a_sel_o = OpAPc;
                ex_op_b_sel_o = OpBIncr;
                gpr_we_a_o    = 1'b1;
                jal_o         = 1'b1;
            end
            OpcJalr: begin
                ex_op_a_sel_o = OpAPc;
                ex_op_b_sel_o = OpBIncr;
                gpr_we_a_o    = 1'b1;
                jalr_o        = 1'b1;
                if (f3 != 3'd0) illegal = 1'b1;
            end
            OpcMiscMem, OpcSystem: ;
            default: illegal = 1'b1;
        endcase

        // Illegal instructions must not leak any side effect into the datapath.
        if (illegal) begin
            ex_op_a_sel_o = OpARs1;
            ex_op_b_sel_o = OpBRs2;
            alu_op_o      = AluAdd;
            mem_req_o     = 1'b0;
            mem_we_o      = 1'b0;
            mem_size_o    = SizeW;
            gpr_we_a_o    = 1'b0;
            wb_src_sel_o  = 1'b0;
            branch_o      = 1'b0;
            jal_o         = 1'b0;
            jalr_o        = 1'b0;
        end
    end

    assign illegal_instr_o = illegal;
    assign illegal_seen_d  = illegal_seen_q | illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) illegal_seen_q <= 1'b0;
        else       illegal_seen_q <= illegal_seen_d;
    end

    assign illegal_seen_o = illegal_seen_q;
endmodule

// File: tb/tb_decoder_core.sv
// Directed, table-driven bench for decoder_core: decode vectors, opcode sweep,
// and the sticky illegal flag's reset behaviour.
module tb_decoder_core;
    typedef struct packed {
        logic [1:0] op_a;
        logic [2:0] op_b;
        logic [4:0] alu;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] size;
        logic       gpr_we;
        logic       wb;
        logic       illegal;
        logic       branch;
        logic       jal;
        logic       jalr;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        out_t        exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] fetched_instr_i;
    logic [1:0]  ex_op_a_sel_o;
    logic [2:0]  ex_op_b_sel_o;
    logic [4:0]  alu_op_o;
    logic        mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o, illegal_instr_o;
    logic [2:0]  mem_size_o;
    logic        branch_o, jal_o, jalr_o, illegal_seen_o;
    out_t        act;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_i = ~clk_i;

    decoder_core dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fetched_instr_i (fetched_instr_i),
        .ex_op_a_sel_o   (ex_op_a_sel_o),
        .ex_op_b_sel_o   (ex_op_b_sel_o),
        .alu_op_o        (alu_op_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_size_o      (mem_size_o),
        .gpr_we_a_o      (gpr_we_a_o),
        .wb_src_sel_o    (wb_src_sel_o),
        .illegal_instr_o (illegal_instr_o),
        .branch_o        (branch_o),
        .jal_o           (jal_o),
        .jalr_o          (jalr_o),
        .illegal_seen_o  (illegal_seen_o)
    );

    assign act = {ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o, mem_size_o,
                  gpr_we_a_o, wb_src_sel_o, illegal_instr_o, branch_o, jal_o, jalr_o};

    task automatic check(input string name, input logic ok, input logic [31:0] a,
                         input logic [31:0] e);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, a, e);
    endtask

    function automatic logic alu_legal(input logic [4:0] a);
        case (a)
            5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b01101, 5'b00110, 5'b00111, 5'b11000, 5'b11001, 5'b11100, 5'b11101,
            5'b11110, 5'b11111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic opc_legal(input logic [4:0] o);
        case (o)
            5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11000,
            5'b11011, 5'b11001, 5'b00011, 5'b11100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Every output encoding legal, and an illegal instruction leaves everything at baseline.
    function automatic logic outputs_sane(input out_t o);
        logic ok;
        ok = (o.op_a <= 2'd2) && (o.op_b <= 3'd4) && alu_legal(o.alu) &&
             (o.size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
             !$isunknown(o);
        if (o.illegal)
            ok = ok && (o == out_t'({2'd0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1,
                                     1'b0, 1'b0, 1'b0}));
        return ok;
    endfunction

    localparam out_t Ill = '{2'd0, 3'd0, 5'b00000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0};

    vec_t vecs[$];

    initial begin
        //                     op_a op_b alu       req we size gwe wb ill br jal jalr
        vecs.push_back('{32'h00500093, '{2'd0, 3'd1, 5'b00000, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h0000A083, '{2'd0, 3'd1, 5'b00000, 1, 0, 3'd2, 1, 1, 0, 0, 0, 0}});
        vecs.push_back('{32'h0000B083, Ill});
        vecs.push_back('{32'h0020A023, '{2'd0, 3'd3, 5'b00000, 1, 1, 3'd2, 0, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h4020D0B3, '{2'd0, 3'd0, 5'b01101, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h0220C0B3, Ill});
        vecs.push_back('{32'h00208463, '{2'd0, 3'd0, 5'b11000, 0, 0, 3'd2, 0, 0, 0, 1, 0, 0}});
        vecs.push_back('{32'h008000EF, '{2'd1, 3'd4, 5'b00000, 0, 0, 3'd2, 1, 0, 0, 0, 1, 0}});
        vecs.push_back('{32'h000080E7, '{2'd1, 3'd4, 5'b00000, 0, 0, 3'd2, 1, 0, 0, 0, 0, 1}});
        vecs.push_back('{32'h00000000, Ill});
        vecs.push_back('{32'h000010B7, '{2'd2, 3'd2, 5'b00000, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h00001097, '{2'd1, 3'd2, 5'b00000, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h4010D093, '{2'd0, 3'd1, 5'b01101, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h40109093, Ill});
        vecs.push_back('{32'h402080B3, '{2'd0, 3'd0, 5'b01000, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h00208023, '{2'd0, 3'd3, 5'b00000, 1, 1, 3'd0, 0, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h0020B023, Ill});
        vecs.push_back('{32'h0000C083, '{2'd0, 3'd1, 5'b00000, 1, 0, 3'd4, 1, 1, 0, 0, 0, 0}});
        vecs.push_back('{32'h0000D083, '{2'd0, 3'd1, 5'b00000, 1, 0, 3'd5, 1, 1, 0, 0, 0, 0}});
        vecs.push_back('{32'h0020A463, Ill});
        vecs.push_back('{32'h0020F463, '{2'd0, 3'd0, 5'b11111, 0, 0, 3'd2, 0, 0, 0, 1, 0, 0}});
        vecs.push_back('{32'h0000000F, '{2'd0, 3'd0, 5'b00000, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h00000073, '{2'd0, 3'd0, 5'b00000, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h000090E7, Ill});
        vecs.push_back('{32'h0FF0F093, '{2'd0, 3'd1, 5'b00111, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0}});
        vecs.push_back('{32'h00500091, Ill});

        rst_i = 1'b1;
        fetched_instr_i = 32'h0000_0000;
        #3;
        check("seen_in_reset", illegal_seen_o == 1'b0, {31'd0, illegal_seen_o}, 32'd0);
        // Decode is independent of reset.
        check("decode_in_reset", illegal_instr_o == 1'b1, {31'd0, illegal_instr_o}, 32'd1);
        fetched_instr_i = 32'h00500093;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("seen_after_reset", illegal_seen_o == 1'b0, {31'd0, illegal_seen_o}, 32'd0);

        foreach (vecs[i]) begin
            fetched_instr_i = vecs[i].instr;
            #1;
            check($sformatf("vec%0d_%h", i, vecs[i].instr), act == vecs[i].exp,
                  {11'd0, act}, {11'd0, vecs[i].exp});
            @(negedge clk_i);
            rst_i = 1'b1;
            #1;
            rst_i = 1'b0;
        end

        for (int o = 0; o < 32; o++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:2] = o[4:0];
            w[1:0] = 2'b11;
            fetched_instr_i = w;
            #1;
            check($sformatf("sweep_sane_%h", w), outputs_sane(act), {11'd0, act}, w);
            if (!opc_legal(o[4:0]))
                check($sformatf("sweep_illegal_%h", w), illegal_instr_o == 1'b1,
                      {31'd0, illegal_instr_o}, 32'd1);
        end
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w;
            w = $urandom;
            fetched_instr_i = w;
            #1;
            check($sformatf("random_sane_%h", w), outputs_sane(act), {11'd0, act}, w);
        end

        // Sticky flag: set by an illegal word, holds, cleared asynchronously.
        @(negedge clk_i);
        rst_i = 1'b1;
        fetched_instr_i = 32'h00500093;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        fetched_instr_i = 32'h0000_0000;
        #1;
        check("seen_before_edge", illegal_seen_o == 1'b0, {31'd0, illegal_seen_o}, 32'd0);
        @(negedge clk_i);
        check("seen_set", illegal_seen_o == 1'b1, {31'd0, illegal_seen_o}, 32'd1);
        fetched_instr_i = 32'h00500093;
        repeat (2) @(negedge clk_i);
        check("seen_holds", illegal_seen_o == 1'b1, {31'd0, illegal_seen_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("seen_async_clear", illegal_seen_o == 1'b0, {31'd0, illegal_seen_o}, 32'd0);
        check("decode_during_rst", alu_op_o == 5'b00000 && gpr_we_a_o == 1'b1,
              {26'd0, alu_op_o, gpr_we_a_o}, 32'd1);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("seen_stays_clear", illegal_seen_o == 1'b0, {31'd0, illegal_seen_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
